matrix_row_reader: RTL and testbench

- Row-streaming reader for flattened matrices. It is the read-side counterpart of the row-insert builder that assembles the pseudo-inverse one row at a time.
- On start, it captures an N x M matrix bus (nBits per element) and emits rows 0..N-1, one row per valid/ready handshake. It pulses done after the last row.
- It sits between the pseudo-inverse result register and downstream row consumers such as the multiplier and output serialiser.

---
 rtl/matrix_row_reader_pkg.sv | 16 +
 rtl/matrix_row_reader_mux.sv | 29 ++
 rtl/matrix_row_reader.sv | 107 ++++++++++
 tb/tb_matrix_row_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_row_reader_pkg.sv
// rtl/matrix_row_reader_pkg.sv - shared state encoding and row-width helper
// for the pseudo-inverse row builder and reader.
package matrix_row_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // Width of one flattened row; shared so builder and reader agree on slicing.
  function automatic int row_w(input int m, input int n_bits);
    return m * n_bits;
  endfunction

endpackage

// File: rtl/matrix_row_reader_mux.sv
// rtl/matrix_row_reader_mux.sv - selects one row slice from a flattened matrix
// buffer by index; output forced to zero when not enabled.
module matrix_row_mux
  import matrix_row_reader_pkg::*;
#(
  parameter int nBits = 32,
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int IDX_W = nBits
) (
  input  logic [0:nBits*N*M-1] i_buf,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic                 i_en,
  output logic [0:M*nBits-1]   o_row
);

  localparam int ROW_W = row_w(M, nBits);

  // Compare-and-select per row keeps the decode shallow and never reads past row N-1.
  always_comb begin
    o_row = '0;
    for (int r = 0; r < N; r++) begin
      if (i_en && (i_idx == IDX_W'(r))) begin
        o_row = i_buf[r*ROW_W +: ROW_W];
      end
    end
  end

endmodule

// File: rtl/matrix_row_reader.sv
// rtl/matrix_row_reader.sv - captures an N x M matrix on start and streams it
// out one row per valid/ready handshake, pulsing done after the last row.
module matrix_row_reader
  import matrix_row_reader_pkg::*;
#(
  parameter int nBits = 32,
  parameter int N     = 4,
  parameter int M     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [0:nBits*N*M-1] matrix,
  output logic [0:M*nBits-1]   row_out,
  output logic [nBits-1:0]     row_idx,
  output logic                 row_valid,
  input  logic                 row_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int ROW_W = row_w(M, nBits);
  localparam logic [nBits-1:0] LAST_IDX = nBits'(N - 1);

  state_e                 r_state;
  logic [0:nBits*N*M-1]   r_buf;
  logic [nBits-1:0]       r_idx;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_stream;
  logic [0:ROW_W-1]       w_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_buf   <= matrix;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          // Abort wins over a coinciding final handshake: no done pulse.
          if (abort) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (row_ready) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + nBits'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_stream = (r_state == S_STREAM);

  matrix_row_mux #(
    .nBits (nBits),
    .N     (N),
    .M     (M),
    .IDX_W (nBits)
  ) u_row_mux (
    .i_buf (r_buf),
    .i_idx (r_idx),
    .i_en  (w_stream),
    .o_row (w_row)
  );

  assign row_out   = w_row;
  assign row_idx   = r_idx;
  assign row_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_matrix_row_reader.sv
// tb/tb_matrix_row_reader.sv - randomized self-checking bench for matrix_row_reader.
module tb_matrix_row_reader;

  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  logic             a_start = 0, a_abort = 0, a_ready = 0;
  logic [0:NB*16-1] a_matrix = '0;
  logic [0:NB*4-1]  a_row_out;
  logic [NB-1:0]    a_row_idx;
  logic             a_row_valid, a_busy, a_done;

  // 1x3 instance
  logic             b_start = 0, b_abort = 0, b_ready = 0;
  logic [0:NB*3-1]  b_matrix = '0;
  logic [0:NB*3-1]  b_row_out;
  logic [NB-1:0]    b_row_idx;
  logic             b_row_valid, b_busy, b_done;

  matrix_row_reader #(.nBits(NB), .N(4), .M(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .matrix(a_matrix),
    .row_out(a_row_out), .row_idx(a_row_idx), .row_valid(a_row_valid),
    .row_ready(a_ready), .busy(a_busy), .done(a_done));

  matrix_row_reader #(.nBits(NB), .N(1), .M(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .matrix(b_matrix),
    .row_out(b_row_out), .row_idx(b_row_idx), .row_valid(b_row_valid),
    .row_ready(b_ready), .busy(b_busy), .done(b_done));

  int n_checks = 0;
  int n_pass   = 0;
  logic [NB-1:0] elem [4][4];

  function automatic logic [0:NB*16-1] pack_matrix();
    logic [0:NB*16-1] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[(r*4+c)*NB +: NB] = elem[r][c];
    return v;
  endfunction

  function automatic logic [0:NB*4-1] exp_row(input int r);
    logic [0:NB*4-1] v;
    for (int c = 0; c < 4; c++) v[c*NB +: NB] = elem[r][c];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        elem[r][c] = NB'(r*16 + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        elem[r][c] = $urandom;
  endtask

  task automatic start_a();
    a_matrix = pack_matrix();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  // Called #1 after the capture edge. Expected row index = number of handshakes so far.
  task automatic stream_and_check(input string name, input int stall_pct,
                                  input int stall_row, input int stall_cycles,
                                  input bit corrupt);
    int got = 0;
    int cyc = 0;
    int stalled = 0;
    while (got < 4 && cyc < 200) begin
      chk({name, "_valid"}, 128'(a_row_valid), 128'(1));
      chk({name, "_busy"}, 128'(a_busy), 128'(1));
      chk({name, "_done_low"}, 128'(a_done), 128'(0));
      chk({name, "_idx"}, 128'(a_row_idx), 128'(got));
      chk({name, "_row"}, 128'(a_row_out), 128'(exp_row(got)));
      if (got == stall_row && stalled < stall_cycles) begin
        a_ready = 1'b0;
        stalled++;
      end else begin
        a_ready = ($urandom_range(99) >= stall_pct);
      end
      if (corrupt) begin
        a_matrix = {16{32'hFFFF_FFFF}};
        a_start  = 1'b1;
      end
      tick();
      if (a_ready) got++;
      cyc++;
    end
    a_start = 1'b0;
    a_ready = 1'b0;
    chk({name, "_rows_seen"}, 128'(got), 128'(4));
    chk({name, "_done"}, 128'(a_done), 128'(1));
    chk({name, "_valid_in_done"}, 128'(a_row_valid), 128'(0));
    chk({name, "_busy_in_done"}, 128'(a_busy), 128'(0));
    chk({name, "_row_zero"}, 128'(a_row_out), 128'(0));
    tick();
    chk({name, "_done_one_cycle"}, 128'(a_done), 128'(0));
    chk({name, "_no_restart"}, 128'(a_row_valid), 128'(0));
    tick();
    chk({name, "_idle_busy"}, 128'(a_busy), 128'(0));
  endtask

  task automatic test_reset();
    chk("reset_a_valid", 128'(a_row_valid), 128'(0));
    chk("reset_a_idx", 128'(a_row_idx), 128'(0));
    chk("reset_a_busy", 128'(a_busy), 128'(0));
    chk("reset_a_done", 128'(a_done), 128'(0));
    chk("reset_a_row", 128'(a_row_out), 128'(0));
    chk("reset_b_valid", 128'(b_row_valid), 128'(0));
    chk("reset_b_row", 128'(b_row_out), 128'(0));
  endtask

  task automatic test_streaming();
    fill_pattern();
    chk("stream_idle_before", 128'(a_row_valid), 128'(0));
    start_a();
    chk("stream_row2_literal", 128'(exp_row(2)),
        128'({32'h20, 32'h21, 32'h22, 32'h23}));
    stream_and_check("stream", 0, -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    fill_random();
    start_a();
    stream_and_check("stall", 0, 1, 3, 1'b0);
    fill_random();
    start_a();
    stream_and_check("rand_stall", 40, -1, 0, 1'b0);
  endtask

  task automatic test_isolation();
    fill_random();
    start_a();
    stream_and_check("isolate", 20, -1, 0, 1'b1);
  endtask

  task automatic test_abort();
    fill_random();
    start_a();
    a_ready = 1'b1;
    tick(); tick(); tick();
    chk("abort_at_row3", 128'(a_row_idx), 128'(3));
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    a_ready = 1'b0;
    chk("abort_valid", 128'(a_row_valid), 128'(0));
    chk("abort_idx", 128'(a_row_idx), 128'(0));
    chk("abort_done", 128'(a_done), 128'(0));
    chk("abort_busy", 128'(a_busy), 128'(0));
    tick();
    chk("abort_no_late_done", 128'(a_done), 128'(0));
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_idle_noeffect", 128'(a_row_valid), 128'(0));
    fill_random();
    start_a();
    stream_and_check("after_abort", 30, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_stream();
    bit saw_done = 0;
    fill_random();
    start_a();
    a_ready = 1'b1;
    tick(); tick();
    a_ready = 1'b0;
    chk("rst_mid_at_row2", 128'(a_row_idx), 128'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(a_row_valid), 128'(0));
    chk("rst_mid_idx", 128'(a_row_idx), 128'(0));
    chk("rst_mid_busy", 128'(a_busy), 128'(0));
    chk("rst_mid_row", 128'(a_row_out), 128'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_done) saw_done = 1;
    end
    rst_n = 1'b1;
    tick();
    if (a_done) saw_done = 1;
    chk("rst_mid_no_done", 128'(saw_done), 128'(0));
    chk("rst_mid_idle", 128'(a_row_valid), 128'(0));
    fill_random();
    start_a();
    stream_and_check("after_reset", 30, -1, 0, 1'b0);
  endtask

  task automatic test_single_row();
    logic [NB-1:0] e [3];
    logic [0:NB*3-1] v;
    int stall;
    for (int c = 0; c < 3; c++) begin
      e[c] = $urandom;
      v[c*NB +: NB] = e[c];
    end
    b_matrix = v;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    stall = $urandom_range(1, 3);
    for (int i = 0; i < stall; i++) begin
      chk("single_valid_stall", 128'(b_row_valid), 128'(1));
      chk("single_row_stall", 128'(b_row_out), 128'({e[0], e[1], e[2]}));
      tick();
    end
    chk("single_idx", 128'(b_row_idx), 128'(0));
    chk("single_done_low", 128'(b_done), 128'(0));
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    chk("single_done", 128'(b_done), 128'(1));
    chk("single_valid_off", 128'(b_row_valid), 128'(0));
    tick();
    chk("single_done_pulse", 128'(b_done), 128'(0));
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_streaming();
    test_stall();
    test_isolation();
    test_abort();
    test_reset_mid_stream();
    test_single_row();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
